ham_encode_engine: RTL and testbench
====================================

Name: ham_encode_engine

Overview:
Hardware Hamming(16,11) SECDED encoder that sits beside the data memory (dm1) in top_level. It takes the top-level req/done handshake. On req it walks the 15 source messages stored as byte pairs and writes each 16-bit encoded word back into the destination region. Its traffic is what the program-1 bench checks at core[30..59].

Parameters:
NUM_MSG, 15, number of messages encoded per request
SRC_BASE, 0, byte address of first source message (low byte; high byte at +1)
DST_BASE, 30, byte address of first encoded word (low byte; high byte at +1)
AW, 8, memory address width
DW, 8, memory data width (fixed 8; other values unsupported)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  start request, sampled only in IDLE or DONE
done  out  1  encoding complete; held until next accepted req
mem_addr  out  AW  byte address to data memory
mem_rd_data  in  DW  data memory read data (combinational read of mem_addr)
mem_wr_en  out  1  data memory write enable, write on rising clk
mem_wr_data  out  DW  data memory write data

Behaviour:
- Reset (reset=0, any time, including mid-run): state IDLE; idx=0; done=0; mem_wr_en=0; mem_addr=0; mem_wr_data=0; captured data cleared.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. 4 cycles per message.
- IDLE/DONE: req=1 at an edge -> RD_LO, idx=0, done=0. Otherwise hold. DONE keeps done=1.
- RD_LO: mem_addr=SRC_BASE+2*idx; capture mem_rd_data as d[8:1] at edge -> RD_HI.
- RD_HI: mem_addr=SRC_BASE+2*idx+1; capture mem_rd_data[2:0] as d[11:9] at edge; bits [7:3] ignored -> WR_LO.
- WR_LO: mem_wr_en=1, mem_addr=DST_BASE+2*idx, mem_wr_data={d4,d3,d2,p4,d1,p2,p1,p0} -> WR_HI.
- WR_HI: mem_wr_en=1, mem_addr=DST_BASE+2*idx+1, mem_wr_data={d11..d5,p8}. If idx==NUM_MSG-1 -> DONE; else idx++ -> RD_LO.
- Parity: p8=^d[11:5]; p4=^d[11:8]^(^d[4:2]); p2=d11^d10^d7^d6^d4^d3^d1; p1=d11^d9^d7^d5^d4^d2^d1; p0=^d[11:1]^p8^p4^p2^p1.
- Latency: req sampled at edge 0 -> done=1 after edge 4*NUM_MSG+1 (61 cycles at default).
- mem_wr_en is 0 in every state except WR_LO/WR_HI. Outputs are registered-state decoded with no glitch on mem_wr_en.
- req while busy (RD_*/WR_*) is ignored. req held high in DONE restarts immediately and done drops.
- Address arithmetic is modulo 2^AW. Overlapping src/dst regions are not protected against.

Optional Feature:
HAM_STATUS_EN: when defined, adds outputs busy (1, high in RD_LO..WR_HI) and msg_cnt (4 bits, messages fully written since last accepted req; reset 0, increments at WR_HI edge, saturates at NUM_MSG). When undefined, neither port nor logic exists and the core behaviour is identical.

Decomposition:
- Package ham_pkg: state enum ham_state_t, default SRC_BASE/DST_BASE/NUM_MSG constants, and the byte-layout bit positions.
- One sub-module: ham_parity16, combinational, d[11:1] in -> {hi,lo} 16-bit codeword out. The engine instantiates it and only sequences memory.

Test Plan:
- All-zero memory, req pulse -> core[30..59] all 8'h00, done rises 61 cycles after req edge.
- Msg0 core[0]=8'h01, core[1]=8'h00 (d=11'h001) -> core[30]=8'h0F, core[31]=8'h00.
- Msg0 core[0]=8'h00, core[1]=8'h04 (d=11'h400) -> core[30]=8'h17, core[31]=8'h81. Msg1 core[2]=8'hFF, core[3]=8'hFF (d=11'h7FF, bits[7:3] ignored) -> core[32]=8'hFF, core[33]=8'hFF.
- 15 random messages vs reference model of the parity equations above -> 15/15 matches; mem_wr_en high exactly 30 cycles.
- reset driven low at cycle 20 of a run -> done=0, mem_wr_en=0 immediately. New req after release -> full correct run from idx 0.
- req pulsed again at cycle 10 (busy) -> ignored, done at 61. req after done -> done falls next cycle and a second run completes identically.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared definitions for the Hamming(16,11) encode engine: default memory map,
// FSM state encoding and the bit positions of the 11-bit message within its byte pair.
package ham_pkg;

   localparam int HAM_NUM_MSG  = 15;
   localparam int HAM_SRC_BASE = 0;
   localparam int HAM_DST_BASE = 30;
   localparam int HAM_AW       = 8;
   localparam int HAM_DW       = 8;

   // Bit 2 set only in the two write states so the write enable is a single flop output.
   typedef enum logic [2:0] {
      HAM_IDLE  = 3'b000,
      HAM_RD_LO = 3'b001,
      HAM_RD_HI = 3'b010,
      HAM_DONE  = 3'b011,
      HAM_WR_LO = 3'b100,
      HAM_WR_HI = 3'b101
   } ham_state_t;

   localparam int LO_D_LSB = 1;
   localparam int LO_D_MSB = 8;
   localparam int HI_D_LSB = 9;
   localparam int HI_D_MSB = 11;
   localparam int HI_D_W   = HI_D_MSB - HI_D_LSB + 1;

endpackage

// File: rtl/ham_parity16.sv
// Combinational Hamming(16,11) SECDED codeword builder.
// Output is {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}: high byte then low byte.
module ham_parity16
   import ham_pkg::*;
(
   input  logic [11:1] i_d,
   output logic [15:0] o_code
);

   logic w_p8;
   logic w_p4;
   logic w_p2;
   logic w_p1;
   logic w_p0;

   assign w_p8 = ^i_d[11:5];
   assign w_p4 = (^i_d[11:8]) ^ (^i_d[4:2]);
   assign w_p2 = i_d[11] ^ i_d[10] ^ i_d[7] ^ i_d[6] ^ i_d[4] ^ i_d[3] ^ i_d[1];
   assign w_p1 = i_d[11] ^ i_d[9] ^ i_d[7] ^ i_d[5] ^ i_d[4] ^ i_d[2] ^ i_d[1];
   // Overall parity covers data and all Hamming bits for double-error detection.
   assign w_p0 = (^i_d[11:1]) ^ w_p8 ^ w_p4 ^ w_p2 ^ w_p1;

   assign o_code = {i_d[11:5], w_p8, i_d[4:2], w_p4, i_d[1], w_p2, w_p1, w_p0};

endmodule

// File: rtl/ham_encode_engine.sv
// Memory-side sequencer: reads NUM_MSG byte-pair messages, writes Hamming(16,11) codewords.
// Optional macro HAM_STATUS_EN adds busy and msg_cnt status outputs.
module ham_encode_engine
   import ham_pkg::*;
#(
   parameter int NUM_MSG  = HAM_NUM_MSG,
   parameter int SRC_BASE = HAM_SRC_BASE,
   parameter int DST_BASE = HAM_DST_BASE,
   parameter int AW       = HAM_AW,
   parameter int DW       = HAM_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rd_data,
   output logic          mem_wr_en,
   output logic [DW-1:0] mem_wr_data
`ifdef HAM_STATUS_EN
   ,
   output logic          busy,
   output logic [3:0]    msg_cnt
`endif
);

   localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_MSG - 1);

   localparam logic [2:0] ST_IDLE  = HAM_IDLE;
   localparam logic [2:0] ST_RD_LO = HAM_RD_LO;
   localparam logic [2:0] ST_RD_HI = HAM_RD_HI;
   localparam logic [2:0] ST_DONE  = HAM_DONE;
   localparam logic [2:0] ST_WR_LO = HAM_WR_LO;
   localparam logic [2:0] ST_WR_HI = HAM_WR_HI;

   logic [2:0]    r_state;
   logic [IW-1:0] r_idx;
   logic [11:1]   r_data;
   logic          r_done;

   logic          w_accept;
   logic [AW-1:0] w_src_lo;
   logic [AW-1:0] w_dst_lo;
   logic [15:0]   w_code;

   assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && req;
   assign w_src_lo = AW'(SRC_BASE) + AW'({r_idx, 1'b0});
   assign w_dst_lo = AW'(DST_BASE) + AW'({r_idx, 1'b0});

   ham_parity16 u_parity (
      .i_d    (r_data),
      .o_code (w_code)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (req) begin
                  r_state <= ST_RD_LO;
                  r_idx   <= '0;
                  r_done  <= 1'b0;
               end else if (r_state == ST_DONE) begin
                  // done is asserted one cycle after the final write has landed
                  r_done  <= 1'b1;
               end
            end
            ST_RD_LO: begin
               r_data[LO_D_MSB:LO_D_LSB] <= mem_rd_data[LO_D_MSB-LO_D_LSB:0];
               r_state                   <= ST_RD_HI;
            end
            ST_RD_HI: begin
               r_data[HI_D_MSB:HI_D_LSB] <= mem_rd_data[HI_D_W-1:0];
               r_state                   <= ST_WR_LO;
            end
            ST_WR_LO: begin
               r_state <= ST_WR_HI;
            end
            ST_WR_HI: begin
               if (r_idx == IDX_LAST) begin
                  r_state <= ST_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= ST_RD_LO;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      mem_addr    = '0;
      mem_wr_data = '0;
      case (r_state)
         ST_RD_LO: mem_addr = w_src_lo;
         ST_RD_HI: mem_addr = w_src_lo + AW'(1);
         ST_WR_LO: begin
            mem_addr    = w_dst_lo;
            mem_wr_data = DW'(w_code[7:0]);
         end
         ST_WR_HI: begin
            mem_addr    = w_dst_lo + AW'(1);
            mem_wr_data = DW'(w_code[15:8]);
         end
         default: begin
            mem_addr    = '0;
            mem_wr_data = '0;
         end
      endcase
   end

   assign mem_wr_en = r_state[2];
   assign done      = r_done;

`ifdef HAM_STATUS_EN
   logic [3:0] r_msg_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_msg_cnt <= '0;
      end else if (w_accept) begin
         r_msg_cnt <= '0;
      end else if ((r_state == ST_WR_HI) && (r_msg_cnt != 4'(NUM_MSG))) begin
         r_msg_cnt <= r_msg_cnt + 4'd1;
      end
   end

   assign busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign msg_cnt = r_msg_cnt;
`else
   logic w_unused_accept;
   assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_ham_encode_engine.sv
// Directed self-checking bench for ham_encode_engine with a byte-wide memory model.
// Status outputs are checked only when HAM_STATUS_EN is defined.
module tb_ham_encode_engine;

   logic       clk;
   logic       reset;
   logic       req;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_wr_en;
   logic [7:0] mem_wr_data;
`ifdef HAM_STATUS_EN
   logic       busy;
   logic [3:0] msg_cnt;
`endif

   logic [7:0] mem     [256];
   logic [7:0] pre_mem [256];
   logic [7:0] snap    [30];
   logic       load_req;

   int checks = 0;
   int errors = 0;

   logic [7:0] vec_exp [8] = '{8'h0F, 8'h00, 8'h17, 8'h81, 8'hFF, 8'hFF, 8'h00, 8'h00};

   ham_encode_engine dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data)
`ifdef HAM_STATUS_EN
      ,
      .busy        (busy),
      .msg_cnt     (msg_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd_data = mem[mem_addr];

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= pre_mem[i];
      end else if (mem_wr_en) begin
         mem[mem_addr] <= mem_wr_data;
      end
   end

   function automatic logic [15:0] ref_enc(input logic [7:0] lo, input logic [7:0] hi);
      logic [11:1] d;
      logic p8, p4, p2, p1, p0;
      d  = {hi[2:0], lo};
      p8 = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[7] ^ d[6] ^ d[5];
      p4 = d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[4] ^ d[3] ^ d[2];
      p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
      return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
   endfunction

   task automatic load_mem();
      @(posedge clk); #1;
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   // Leaves the bench at #1 after the edge that samples req (edge 0).
   task automatic start_run();
      @(posedge clk); #1;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic wait_done(input int start_edge, output int done_edge, output int wr_cnt);
      done_edge = -1;
      wr_cnt    = 0;
      for (int e = start_edge + 1; e <= start_edge + 200; e++) begin
         @(posedge clk); #1;
         if (mem_wr_en) wr_cnt++;
         if (done) begin
            done_edge = e;
            break;
         end
      end
      $display("run: done_edge=%0d writes=%0d", done_edge, wr_cnt);
   endtask

   task automatic check_dest_vs_model(input string tag);
      logic [15:0] exp_w, got_w;
      for (int m = 0; m < 15; m++) begin
         exp_w = ref_enc(pre_mem[2*m], pre_mem[2*m+1]);
         got_w = {mem[31+2*m], mem[30+2*m]};
         checks++;
         if (got_w !== exp_w) begin
            errors++;
            $display("FAIL %s msg%0d: got %04h expected %04h", tag, m, got_w, exp_w);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %02h expected 00", mem_addr); end
      checks++; if (mem_wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %02h expected 00", mem_wr_data); end
      reset = 1'b1;
      $display("reset: released");
   endtask

   task automatic test_all_zero();
      int de, wc;
      for (int i = 0; i < 256; i++) pre_mem[i] = (i >= 30 && i < 60) ? 8'hAA : 8'h00;
      load_mem();
      start_run();
      wait_done(0, de, wc);
      checks++; if (de !== 61) begin errors++; $display("FAIL zero_done_edge: got %0d expected 61", de); end
      checks++; if (wc !== 30) begin errors++; $display("FAIL zero_wr_cycles: got %0d expected 30", wc); end
      for (int a = 30; a < 60; a++) begin
         checks++;
         if (mem[a] !== 8'h00) begin errors++; $display("FAIL zero_dest[%0d]: got %02h expected 00", a, mem[a]); end
      end
`ifdef HAM_STATUS_EN
      checks++; if (msg_cnt !== 4'd15) begin errors++; $display("FAIL status_msg_cnt: got %0d expected 15", msg_cnt); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL status_busy: got %b expected 0", busy); end
`endif
   endtask

   task automatic test_vectors();
      int de, wc;
      for (int i = 0; i < 256; i++) pre_mem[i] = 8'h00;
      pre_mem[0] = 8'h01; pre_mem[1] = 8'h00;
      pre_mem[2] = 8'h00; pre_mem[3] = 8'h04;
      pre_mem[4] = 8'hFF; pre_mem[5] = 8'hFF;
      pre_mem[6] = 8'h00; pre_mem[7] = 8'hF8;
      load_mem();
      start_run();
      wait_done(0, de, wc);
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (mem[30+k] !== vec_exp[k]) begin
            errors++;
            $display("FAIL vector_dest[%0d]: got %02h expected %02h", 30 + k, mem[30+k], vec_exp[k]);
         end
      end
   endtask

   task automatic test_random();
      int de, wc;
      for (int i = 0; i < 256; i++) pre_mem[i] = 8'h00;
      for (int i = 0; i < 30; i++) pre_mem[i] = 8'($urandom_range(0, 255));
      load_mem();
      start_run();
      wait_done(0, de, wc);
      checks++; if (de !== 61) begin errors++; $display("FAIL random_done_edge: got %0d expected 61", de); end
      checks++; if (wc !== 30) begin errors++; $display("FAIL random_wr_cycles: got %0d expected 30", wc); end
      check_dest_vs_model("random");
   endtask

   task automatic test_reset_mid();
      int de, wc;
      for (int i = 30; i < 60; i++) pre_mem[i] = 8'h00;
      load_mem();
      start_run();
      repeat (19) begin @(posedge clk); #1; end
      checks++; if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL midrun_wr_en_before: got %b expected 1", mem_wr_en); end
      reset = 1'b0;
      #1;
      checks++; if (done !== 1'b0)      begin errors++; $display("FAIL midrun_done: got %b expected 0", done); end
      checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL midrun_wr_en: got %b expected 0", mem_wr_en); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL midrun_addr: got %02h expected 00", mem_addr); end
      @(posedge clk); #1;
      reset = 1'b1;
      start_run();
      wait_done(0, de, wc);
      checks++; if (de !== 61) begin errors++; $display("FAIL rerun_done_edge: got %0d expected 61", de); end
      checks++; if (wc !== 30) begin errors++; $display("FAIL rerun_wr_cycles: got %0d expected 30", wc); end
      check_dest_vs_model("rerun");
      reset = 1'b0;
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_reset: got %b expected 0", done); end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_back_to_back();
      int de, wc;
      start_run();
      repeat (10) begin @(posedge clk); #1; end
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      wait_done(11, de, wc);
      checks++; if (de !== 61) begin errors++; $display("FAIL busy_req_done_edge: got %0d expected 61", de); end
      for (int i = 0; i < 30; i++) snap[i] = mem[30+i];
      for (int i = 30; i < 60; i++) pre_mem[i] = 8'h00;
      load_mem();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_hold: got %b expected 1", done); end
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done_drop: got %b expected 0", done); end
      wait_done(0, de, wc);
      checks++; if (de !== 61) begin errors++; $display("FAIL second_done_edge: got %0d expected 61", de); end
      for (int i = 0; i < 30; i++) begin
         checks++;
         if (mem[30+i] !== snap[i]) begin
            errors++;
            $display("FAIL second_run_dest[%0d]: got %02h expected %02h", 30 + i, mem[30+i], snap[i]);
         end
      end
   endtask

   initial begin
      reset    = 1'b0;
      req      = 1'b0;
      load_req = 1'b0;
      for (int i = 0; i < 256; i++) pre_mem[i] = 8'h00;
      test_reset();
      test_all_zero();
      test_vectors();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
